// File: rtl/snake_pkg.sv
// Shared encodings for the snake move scheduler: headings, plot colours, FSM states.
package snake_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_GREEN = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ERASE  = 3'd2,
    S_CHECK  = 3'd3,
    S_STEP   = 3'd4,
    S_SETTLE = 3'd5,
    S_DRAW   = 3'd6,
    S_DEAD   = 3'd7
  } state_t;

endpackage

// File: rtl/snake_tick_gen.sv
// Move prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick on the last count.
module snake_tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Terminal count fires for one cycle and wraps the counter; clear holds it at zero.
  always_comb begin
    tick_o = !clear_i && (cnt_q == LAST);
    cnt_d  = (clear_i || tick_o) ? '0 : cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/snake_move_scheduler.sv
// Per-tick sequencer for the snake head: erase old block, bound check, step, draw new block.
module snake_move_scheduler
  import snake_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000,
  parameter int BLK      = 4,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       go_right,
  input  logic       go_left,
  input  logic [7:0] head_x,
  input  logic [6:0] head_y,
  output logic       step,
  output logic       add_x,
  output logic       sub_x,
  output logic       add_y,
  output logic       sub_y,
  output logic       plot,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       game_over,
  output logic       busy
);

  localparam int LB = $clog2(BLK);
  localparam int PW = (LB == 0) ? 1 : 2 * LB;
  localparam logic [PW-1:0] LASTPIX = PW'(BLK * BLK - 1);
  localparam logic [PW-1:0] BLKP    = PW'(BLK);
  localparam logic [8:0] SPAN9 = 9'(2 * BLK - 1);
  localparam logic [8:0] BLK9  = 9'(BLK);
  localparam logic [8:0] XM9   = 9'(X_MAX);
  localparam logic [8:0] YM9   = 9'(Y_MAX);

  state_t        state_q, state_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [1:0]    dir_q, dir_d, dir_new;
  logic          go_r_q, go_l_q, pend_q, pend_right_q, pend_clr;
  logic          edge_r, edge_l, cap_en, tick, dead;
  logic          plot_q, plot_d, step_q, step_d, game_over_q, game_over_d, busy_q, busy_d;
  logic [3:0]    mv_q, mv_d;
  logic [7:0]    x_q, x_d, col;
  logic [6:0]    y_q, y_d, row;
  logic [2:0]    colour_q, colour_d;
  logic [8:0]    hx9, hy9;

  snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i   (clk),
    .rst_i   (reset),
    .clear_i (state_q != S_WAIT),
    .tick_o  (tick)
  );

  // Heading after the pending turn, and whether the step along it would leave the screen.
  always_comb begin
    dir_new = dir_q;
    if (pend_q) dir_new = pend_right_q ? dir_q + 2'd1 : dir_q - 2'd1;
    hx9 = {1'b0, head_x};
    hy9 = {2'b0, head_y};
    col = 8'(pix_q % BLKP);
    row = 7'(pix_q / BLKP);
    case (dir_new)
      DIR_RIGHT: dead = (hx9 + SPAN9) > XM9;
      DIR_LEFT:  dead = hx9 < BLK9;
      DIR_DOWN:  dead = (hy9 + SPAN9) > YM9;
      default:   dead = hy9 < BLK9;
    endcase
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    dir_d       = dir_q;
    pend_clr    = 1'b0;
    plot_d      = 1'b0;
    step_d      = 1'b0;
    mv_d        = 4'b0000;
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    game_over_d = game_over_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_DRAW;
        pix_d   = '0;
      end
      S_WAIT: if (tick) state_d = S_ERASE;
      S_ERASE, S_DRAW: begin
        plot_d   = 1'b1;
        colour_d = (state_q == S_ERASE) ? COL_BLACK : COL_GREEN;
        x_d      = head_x + col;
        y_d      = head_y + row;
        if (pix_q == LASTPIX) begin
          pix_d   = '0;
          state_d = (state_q == S_ERASE) ? S_CHECK : S_WAIT;
        end else begin
          pix_d = pix_q + PW'(1);
        end
      end
      S_CHECK: begin
        dir_d    = dir_new;
        pend_clr = 1'b1;
        if (dead) begin
          state_d     = S_DEAD;
          game_over_d = 1'b1;
        end else begin
          state_d = S_STEP;
          step_d  = 1'b1;
          case (dir_new)
            DIR_RIGHT: mv_d = 4'b1000;
            DIR_LEFT:  mv_d = 4'b0100;
            DIR_DOWN:  mv_d = 4'b0010;
            default:   mv_d = 4'b0001;
          endcase
        end
      end
      S_STEP:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_DRAW;
      default:  game_over_d = 1'b1;
    endcase
    busy_d = (state_d == S_ERASE) || (state_d == S_CHECK) || (state_d == S_STEP) ||
             (state_d == S_SETTLE) || (state_d == S_DRAW);
  end

  // State, pixel counter, heading and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pix_q       <= '0;
      dir_q       <= DIR_RIGHT;
      plot_q      <= 1'b0;
      step_q      <= 1'b0;
      mv_q        <= 4'b0000;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= COL_BLACK;
      game_over_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      dir_q       <= dir_d;
      plot_q      <= plot_d;
      step_q      <= step_d;
      mv_q        <= mv_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
      game_over_q <= game_over_d;
      busy_q      <= busy_d;
    end
  end

  // Turn latch: edges are only taken while a game runs, so a button held through reset
  // or pressed before start never turns the snake; a simultaneous double edge is dropped.
  always_comb begin
    edge_r = go_right & ~go_r_q;
    edge_l = go_left & ~go_l_q;
    cap_en = (state_q != S_IDLE) && (state_q != S_DEAD);
  end

  // Button history and the single pending turn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go_r_q       <= 1'b0;
      go_l_q       <= 1'b0;
      pend_q       <= 1'b0;
      pend_right_q <= 1'b0;
    end else begin
      go_r_q <= go_right;
      go_l_q <= go_left;
      if (pend_clr) begin
        pend_q <= 1'b0;
      end else if (cap_en && !pend_q && (edge_r ^ edge_l)) begin
        pend_q       <= 1'b1;
        pend_right_q <= edge_r;
      end
    end
  end

  assign plot      = plot_q;
  assign step      = step_q;
  assign {add_x, sub_x, add_y, sub_y} = mv_q;
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign game_over = game_over_q;
  assign busy      = busy_q;

endmodule
